// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: opcodes, FSM encoding and width defaults.
package alu_pkg;

    localparam int unsigned W_DEF = 32;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_ADD     = 3'd1,
        OP_SUB     = 3'd2,
        OP_AND     = 3'd3,
        OP_OR      = 3'd4,
        OP_XOR     = 3'd5,
        OP_NOR     = 3'd6,
        OP_ILLEGAL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Only arithmetic ops may report signed overflow.
    function automatic logic op_has_ovf(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // NOP and the illegal encoding produce a zero result regardless of the ALU.
    function automatic logic op_is_null(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin grant; purely combinational, pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last,
    output logic       o_grant_valid_c,
    output logic       o_grant_id_c
);

    always_comb begin
        o_grant_valid_c = |i_req_valid;
        o_grant_id_c    = 1'b0;
        if (i_req_valid == 2'b11) begin
            o_grant_id_c = ~i_last;
        end else if (i_req_valid[1]) begin
            o_grant_id_c = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two clients onto one external ALU and returns results through a held response handshake.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [W-1:0]     resp_data,
    output logic             resp_ovf,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [W-1:0]     alu_out,
    input  logic             alu_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_last;
    logic              r_id;
    logic [W-1:0]      r_alu_a;
    logic [W-1:0]      r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [W-1:0]      r_resp_data;
    logic              r_resp_ovf;
    logic [CNT_W-1:0]  r_ops_done;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_req_hs;
    logic              w_resp_hs;

    rr_arb2 u_arb (
        .i_req_valid     (req_valid),
        .i_last          (r_last),
        .o_grant_valid_c (w_gnt_valid),
        .o_grant_id_c    (w_gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the combinational request ready (only ever high in IDLE).
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        w_req_hs    = 1'b0;
        w_resp_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    req_ready[w_gnt_id] = 1'b1;
                    w_req_hs            = 1'b1;
                    w_state_nxt         = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready[r_id]) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_resp_data <= '0;
            r_resp_ovf  <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            if (w_req_hs) begin
                r_id     <= w_gnt_id;
                r_alu_a  <= w_gnt_id ? req_a1  : req_a0;
                r_alu_b  <= w_gnt_id ? req_b1  : req_b0;
                r_alu_op <= w_gnt_id ? req_op1 : req_op0;
            end
            if (r_state == ST_EXEC) begin
                r_last <= r_id;
                if (op_is_null(r_alu_op)) begin
                    r_resp_data <= '0;
                    r_resp_ovf  <= 1'b0;
                end else begin
                    r_resp_data <= alu_out;
                    r_resp_ovf  <= alu_overflow & op_has_ovf(r_alu_op);
                end
            end
            if (w_resp_hs) begin
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (r_state != ST_IDLE);
    assign resp_data  = r_resp_data;
    assign resp_ovf   = r_resp_ovf;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign ops_done   = r_ops_done;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester arbiter and sequencer for the shared 32-bit ALU in the MIPS CPU datapath. It accepts operations from two clients, for example the execute stage and a multi-cycle helper, through valid/ready handshakes. Grants are round-robin. The controller drives registered operands and opcode into one external ALU instance, captures the result and overflow, and returns them to the granted client through a held response handshake.

## Interface
- `W`, default 32: operand and result width.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid[1:0]`  in  2  per-client request valid.
- `req_ready[1:0]`  out  2  per-client request ready.
- `req_op0`, `req_op1`  in  3 each  opcode per client.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  W each  operands per client.
- `resp_valid[1:0]`  out  2  per-client response valid.
- `resp_ready[1:0]`  in  2  per-client response accept.
- `resp_data`  out  W  result, shared by both clients.
- `resp_ovf`  out  1  overflow flag, shared.
- `alu_a`, `alu_b`  out  W  registered operands to the ALU.
- `alu_op`  out  3  registered opcode to the ALU.
- `alu_out`  in  W  combinational ALU result.
- `alu_overflow`  in  1  ALU overflow flag.
- `busy`  out  1  high when not in IDLE.
- `ops_done`  out  CNT_W  count of completed response handshakes.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6. Value 7 is illegal.
- States are IDLE, EXEC and RESP.
- **IDLE**
  - `req_ready[i]` = `req_valid[i]` AND (grant==i). It is combinational and low in every other state.
  - Grant rule:
    - If only one client is valid, that client wins.
    - If both are valid, the client not served last wins.
    - The last-served pointer resets to 1, so client 0 wins first.
  - On handshake: latch the client's operands and opcode into `alu_a`/`alu_b`/`alu_op`, store the client id, go to EXEC.
- **EXEC** (exactly one cycle)
  - Capture `alu_out` into `resp_data`.
  - `resp_ovf` = `alu_overflow` AND (op is ADD or SUB). Otherwise it is 0.
  - For NOP or opcode 7, force `resp_data`=0 and `resp_ovf`=0, ignoring the ALU.
  - Update the last-served pointer to the id. Go to RESP.
- **RESP**
  - `resp_valid[id]`=1; the other client's `resp_valid` stays 0.
  - `resp_data`/`resp_ovf` hold stable until `resp_ready[id]`=1.
  - On handshake: `ops_done` += 1, wrapping 2^CNT_W−1 → 0. Go to IDLE.
  - `resp_ready` of the non-owner client is ignored.
- A client may drop `req_valid` before its handshake; no grant results.
- `alu_a`/`alu_b`/`alu_op` change only on an IDLE handshake. Between operations they hold their last values.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=0 (valid-gated), `resp_valid`=0.
  - `resp_data`=0, `resp_ovf`=0.
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.
  - `busy`=0, `ops_done`=0, last-served pointer=1.
- Reset asserted mid-operation aborts the in-flight transaction; no response is issued.
- Latency and throughput:
  - Request handshake at edge N.
  - ALU inputs valid after N; result captured at N+1.
  - `resp_valid` high from after N+1. Minimum latency is 2 cycles.
  - IDLE is re-entered the cycle after the response handshake. Peak throughput is 1 op per 3 cycles.
- No combinational path exists from `resp_ready` to any output except through state.

## Structure
- Shared package `alu_pkg`:
  - opcode constants (NOP…NOR, ILLEGAL=7);
  - state encoding (IDLE=0, EXEC=1, RESP=2);
  - `W` default.
- One natural sub-module, `rr_arb2`: the two-input round-robin grant from `req_valid` and the last-served pointer. It is purely combinational; the pointer register lives in the parent.
- The ALU is instantiated beside this block, not inside it.

## Test plan
The bench uses a behavioural ALU with correct signed overflow.

1. Reset, then client 0 issues ADD a=0x00000005, b=0x00000003 → `req_ready[0]` high, `resp_valid[0]` 2 cycles after handshake, `resp_data`=0x00000008, `resp_ovf`=0, `ops_done`=1.
2. Both clients hold valid with 4 requests each (ops ADD/SUB/XOR/NOR, any operands) → grants alternate 0,1,0,1…; `ops_done`=8 at the end.
3. Client 1 ADD 0x7FFFFFFF+0x00000001 → 0x80000000, ovf=1. Client 0 AND 0xFFFFFFFF&0x80000000 → 0x80000000, ovf=0 (masked).
4. Client 0 NOP, then opcode 7, with ALU driving 0xDEADBEEF → both responses have data=0, ovf=0.
5. `resp_ready[0]` held low for 5 cycles while client 1 requests → `resp_data` stable, `req_ready[1]`=0 until the response completes, then client 1 is granted.
6. `rst_n` pulsed low during EXEC → all outputs return to reset values immediately, no `resp_valid`, and the next request is served normally.
